// File: rtl/regfile_writeback_if.sv
// regfile_writeback_if: ALU/load result streams and register file write port; REGFILE_WB_BYPASS_EN adds decode bypass taps
interface regfile_writeback_if;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_addr_lo;
  logic [31:0] ld_rdata;
  logic [4:0]  write_index;
  logic [31:0] reg_write;
  logic        reg_write_en;
  logic        busy;
`ifdef REGFILE_WB_BYPASS_EN
  logic [4:0]  byp_index_a;
  logic [4:0]  byp_index_b;
  logic        byp_hit_a;
  logic        byp_hit_b;
  logic [31:0] byp_data_a;
  logic [31:0] byp_data_b;
`endif
  modport master (
    output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_funct3, ld_addr_lo, ld_rdata,
`ifdef REGFILE_WB_BYPASS_EN
    output byp_index_a, byp_index_b,
    input  byp_hit_a, byp_hit_b, byp_data_a, byp_data_b,
`endif
    input  ld_ready, write_index, reg_write, reg_write_en, busy
  );
  modport slave (
    input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_funct3, ld_addr_lo, ld_rdata,
`ifdef REGFILE_WB_BYPASS_EN
    input  byp_index_a, byp_index_b,
    output byp_hit_a, byp_hit_b, byp_data_a, byp_data_b,
`endif
    output ld_ready, write_index, reg_write, reg_write_en, busy
  );
endinterface

// File: rtl/regfile_writeback.sv
// regfile_writeback: merges ALU results (priority) and extended loads (in-order queue) onto the register file write port.
// Optional macro REGFILE_WB_BYPASS_EN adds combinational decode bypass outputs.
module regfile_writeback #(
  parameter int DEPTH = 2
) (
  input logic clk,
  input logic rst_n,
  regfile_writeback_if.slave wb
);
  localparam int AW = $clog2(DEPTH);
  logic [4:0]  q_rd   [DEPTH];
  logic [31:0] q_data [DEPTH];
  logic [AW-1:0] head, tail;
  logic [AW:0] count;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] ld_ext;
  logic [4:0]  wr_idx;
  logic [31:0] wr_data;
  logic        wr_en;
  logic accept, non_empty, pop, bypass, push;
  always_comb begin
    byte_v = wb.ld_rdata[{wb.ld_addr_lo, 3'b000} +: 8];
    half_v = wb.ld_rdata[{wb.ld_addr_lo[1], 4'b0000} +: 16];
    ld_ext = wb.ld_funct3 == 3'b000 ? {{24{byte_v[7]}}, byte_v} :
             wb.ld_funct3 == 3'b001 ? {{16{half_v[15]}}, half_v} :
             wb.ld_funct3 == 3'b100 ? {24'd0, byte_v} :
             wb.ld_funct3 == 3'b101 ? {16'd0, half_v} : wb.ld_rdata;
  end
  assign wb.ld_ready = count != (AW+1)'(DEPTH);
  assign accept      = wb.ld_valid && wb.ld_ready;
  assign non_empty   = count != '0;
  assign pop         = !wb.alu_valid && non_empty;
  // Loads to x0 are consumed but never reach the queue or the write port
  assign bypass      = !wb.alu_valid && !non_empty && accept && wb.ld_rd != '0;
  assign push        = accept && wb.ld_rd != '0 && !bypass;
  always_ff @(posedge clk) begin
    if (push) begin
      q_rd[tail]   <= wb.ld_rd;
      q_data[tail] <= ld_ext;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + AW'(pop);
      tail  <= tail + AW'(push);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx  <= '0;
      wr_data <= '0;
      wr_en   <= 1'b0;
    end else if (wb.alu_valid) begin
      wr_idx  <= wb.alu_rd;
      wr_data <= wb.alu_data;
      wr_en   <= wb.alu_rd != '0;
    end else if (non_empty) begin
      wr_idx  <= q_rd[head];
      wr_data <= q_data[head];
      wr_en   <= 1'b1;
    end else if (bypass) begin
      wr_idx  <= wb.ld_rd;
      wr_data <= ld_ext;
      wr_en   <= 1'b1;
    end else begin
      wr_en   <= 1'b0;
    end
  end
  assign wb.write_index  = wr_idx;
  assign wb.reg_write    = wr_data;
  assign wb.reg_write_en = wr_en;
  assign wb.busy         = non_empty;
`ifdef REGFILE_WB_BYPASS_EN
  assign wb.byp_hit_a  = wr_en && wr_idx == wb.byp_index_a && wb.byp_index_a != '0;
  assign wb.byp_hit_b  = wr_en && wr_idx == wb.byp_index_b && wb.byp_index_b != '0;
  assign wb.byp_data_a = wb.byp_hit_a ? wr_data : '0;
  assign wb.byp_data_b = wb.byp_hit_b ? wr_data : '0;
`endif
endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback: directed test-plan steps then randomized traffic against a queue-based reference model.
module tb_regfile_writeback;
  localparam int DEPTH = 2;
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
  } ent_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  ent_t mq[$];
  logic [4:0]  m_idx = '0;
  logic [31:0] m_data = '0;
  logic        m_en = 1'b0;
  regfile_writeback_if wb ();
  regfile_writeback #(.DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .wb(wb));
  always #5 clk = ~clk;

  function automatic logic [31:0] ext(input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] rd);
    logic [31:0] b, h;
    b = (rd >> (8 * lo)) & 32'hFF;
    h = (rd >> (16 * lo[1])) & 32'hFFFF;
    case (f3)
      3'd0: return b >= 32'h80 ? b - 32'h100 : b;
      3'd1: return h >= 32'h8000 ? h - 32'h10000 : h;
      3'd4: return b;
      3'd5: return h;
      default: return rd;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("reg_write_en", 32'(wb.reg_write_en), 32'(m_en));
    chk("write_index", 32'(wb.write_index), 32'(m_idx));
    chk("reg_write", wb.reg_write, m_data);
    chk("ld_ready", 32'(wb.ld_ready), 32'(mq.size() < DEPTH));
    chk("busy", 32'(wb.busy), 32'(mq.size() != 0));
`ifdef REGFILE_WB_BYPASS_EN
    chk("byp_hit_a", 32'(wb.byp_hit_a), 32'(m_en && m_idx == wb.byp_index_a && wb.byp_index_a != 0));
    chk("byp_hit_b", 32'(wb.byp_hit_b), 32'(m_en && m_idx == wb.byp_index_b && wb.byp_index_b != 0));
    chk("byp_data_a", wb.byp_data_a, (m_en && m_idx == wb.byp_index_a && wb.byp_index_a != 0) ? m_data : 32'd0);
    chk("byp_data_b", wb.byp_data_b, (m_en && m_idx == wb.byp_index_b && wb.byp_index_b != 0) ? m_data : 32'd0);
`endif
  endtask

  // Drive one cycle at a negedge, predict the edge, check at the following negedge
  task automatic cyc(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                     input logic lv, input logic [4:0] lrd, input logic [2:0] f3,
                     input logic [1:0] lo, input logic [31:0] rdata);
    logic acc;
    ent_t e;
    wb.alu_valid = av; wb.alu_rd = ard; wb.alu_data = ad;
    wb.ld_valid = lv; wb.ld_rd = lrd; wb.ld_funct3 = f3; wb.ld_addr_lo = lo; wb.ld_rdata = rdata;
    acc = lv && mq.size() < DEPTH;
    e.rd = lrd;
    e.d = ext(f3, lo, rdata);
    if (av) begin
      m_idx = ard; m_data = ad; m_en = ard != 0;
      if (acc && lrd != 0) mq.push_back(e);
    end else if (mq.size() != 0) begin
      m_idx = mq[0].rd; m_data = mq[0].d; m_en = 1'b1;
      void'(mq.pop_front());
      if (acc && lrd != 0) mq.push_back(e);
    end else if (acc && lrd != 0) begin
      m_idx = lrd; m_data = e.d; m_en = 1'b1;
    end else m_en = 1'b0;
    @(negedge clk);
    chk_all();
  endtask

  task automatic idle();
    cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 3'd0, 2'd0, 32'd0);
  endtask

  task automatic model_reset();
    mq.delete();
    m_idx = '0; m_data = '0; m_en = 1'b0;
  endtask

  initial begin
    wb.alu_valid = 0; wb.alu_rd = 0; wb.alu_data = 0;
    wb.ld_valid = 0; wb.ld_rd = 0; wb.ld_funct3 = 0; wb.ld_addr_lo = 0; wb.ld_rdata = 0;
`ifdef REGFILE_WB_BYPASS_EN
    wb.byp_index_a = 0; wb.byp_index_b = 0;
`endif
    repeat (2) @(negedge clk);
    chk_all();
    rst_n = 1'b1;
    cyc(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 3'd0, 2'd0, 32'd0);
    chk("alu_data", wb.reg_write, 32'h0000_1234);
    chk("alu_idx", 32'(wb.write_index), 32'd5);
    cyc(1'b1, 5'd0, 32'h5555, 1'b0, 5'd0, 3'd0, 2'd0, 32'd0);
    chk("alu_rd0_en", 32'(wb.reg_write_en), 32'd0);
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 3'b000, 2'd3, 32'h80FF_0000);
    chk("lb", wb.reg_write, 32'hFFFF_FF80);
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 3'b101, 2'd2, 32'h80FF_0000);
    chk("lhu", wb.reg_write, 32'h0000_80FF);
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 3'b001, 2'd0, 32'h0000_8001);
    chk("lh", wb.reg_write, 32'hFFFF_8001);
    cyc(1'b1, 5'd4, 32'd4, 1'b1, 5'd1, 3'b010, 2'd0, 32'h11);
    cyc(1'b1, 5'd4, 32'd4, 1'b1, 5'd2, 3'b010, 2'd0, 32'h22);
    chk("full_ready", 32'(wb.ld_ready), 32'd0);
    chk("full_busy", 32'(wb.busy), 32'd1);
    cyc(1'b1, 5'd4, 32'd4, 1'b1, 5'd3, 3'b010, 2'd0, 32'h33);
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 3'b010, 2'd0, 32'h33);
    chk("drain1", 32'(wb.write_index), 32'd1);
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 3'b010, 2'd0, 32'h33);
    chk("drain2", 32'(wb.write_index), 32'd2);
    cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 3'b010, 2'd0, 32'h0);
    chk("drain3", wb.reg_write, 32'h33);
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 3'b010, 2'd0, 32'hABCD);
    chk("ld_x0_en", 32'(wb.reg_write_en), 32'd0);
    chk("ld_x0_busy", 32'(wb.busy), 32'd0);
`ifdef REGFILE_WB_BYPASS_EN
    wb.byp_index_a = 5'd7; wb.byp_index_b = 5'd0;
    cyc(1'b1, 5'd7, 32'hDEAD, 1'b0, 5'd0, 3'd0, 2'd0, 32'd0);
    chk("byp_a_hit", 32'(wb.byp_hit_a), 32'd1);
    chk("byp_a_data", wb.byp_data_a, 32'hDEAD);
    chk("byp_b_hit", 32'(wb.byp_hit_b), 32'd0);
`endif
    cyc(1'b1, 5'd6, 32'd6, 1'b1, 5'd10, 3'b010, 2'd0, 32'hAA);
    cyc(1'b1, 5'd6, 32'd6, 1'b1, 5'd11, 3'b010, 2'd0, 32'hBB);
    chk("pre_rst_busy", 32'(wb.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk_all();
    wb.alu_valid = 1'b1; wb.alu_rd = 5'd3; wb.ld_valid = 1'b1; wb.ld_rd = 5'd12;
    @(negedge clk);
    chk_all();
    rst_n = 1'b1;
    repeat (3) idle();
    for (int i = 0; i < 400; i++) begin
`ifdef REGFILE_WB_BYPASS_EN
      wb.byp_index_a = 5'($urandom_range(0, 7));
      wb.byp_index_b = 5'($urandom_range(0, 7));
`endif
      if ($urandom_range(0, 60) == 0) begin
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk_all();
        @(negedge clk);
        rst_n = 1'b1;
      end else
        cyc($urandom_range(0, 9) < 4, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            2'($urandom_range(0, 3)), $urandom);
    end
    repeat (3) idle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/regfile_writeback.md
# regfile_writeback

- Write-back stage that drives the register file write port (`write_index`, `reg_write`, `reg_write_en`).
- Merges two result streams:
  - Single-cycle ALU results, which always have priority.
  - Load responses from the data-memory interface, under a valid/ready handshake.
- Loads are size/sign-extended, then buffered in a small in-order queue while the ALU holds the port.
- Sits between the execute/memory stages and the register file; retires at most one register write per cycle.

## Interface

Parameters:
- `DEPTH`, 2 — load queue entries; power of two, ≥2.

Ports:
- `clk` in 1 — clock; all state on rising edge.
- `rst_n` in 1 — reset, asynchronous, active-low.
- `alu_valid` in 1 — ALU result present this cycle; no backpressure.
- `alu_rd` in 5 — ALU destination register.
- `alu_data` in 32 — ALU result.
- `ld_valid` in 1 — load response valid.
- `ld_ready` out 1 — load response accepted when `ld_valid && ld_ready`.
- `ld_rd` in 5 — load destination register.
- `ld_funct3` in 3 — load type.
- `ld_addr_lo` in 2 — byte address bits [1:0].
- `ld_rdata` in 32 — raw aligned memory word.
- `write_index` out 5 — register file write index.
- `reg_write` out 32 — register file write data.
- `reg_write_en` out 1 — register file write enable.
- `busy` out 1 — load queue non-empty.

## Operation

- Output stage: `write_index`, `reg_write` and `reg_write_en` are flops, loaded every cycle.
- Selection per cycle, highest priority first:
  1. `alu_valid`: output ← (`alu_rd`, `alu_data`), en = (`alu_rd` != 0).
  2. Else if queue non-empty: pop head into output, en = 1.
  3. Else if a load is accepted this cycle: it goes directly to output (queue bypass), en = 1.
  4. Else en = 0. Index and data hold their previous values.
- Load accept:
  - `ld_ready` = (count != DEPTH). It depends on registered count only, with no combinational path from `alu_valid` or `ld_valid`.
  - An accepted load with `ld_rd` == 0 is consumed and discarded: never queued, never written.
  - An accepted load not taken by rule 3 is pushed at the tail.
- Simultaneous pop and push on a full queue: not possible, because `ld_ready` = 0 when full. With count < DEPTH, pop and push in the same cycle leaves count unchanged.
- Pointers wrap modulo DEPTH; count is $clog2(DEPTH)+1 bits.
- Load extension is applied before queueing. Byte = `ld_rdata[8*ld_addr_lo +: 8]`; half = `ld_rdata[16*ld_addr_lo[1] +: 16]`.
  - 000 LB: sign-extend byte.
  - 001 LH: sign-extend half.
  - 010 LW: full word.
  - 100 LBU: zero-extend byte.
  - 101 LHU: zero-extend half.
  - Other codes: full word.
- Ordering:
  - Loads retire in acceptance order.
  - ALU writes may overtake queued loads. The issue logic guarantees no in-flight load shares an rd with a later ALU op.
- Reset (`rst_n` low, async):
  - Queue emptied, pointers and count 0.
  - `write_index` = 0, `reg_write` = 0, `reg_write_en` = 0, `busy` = 0.
  - `ld_ready` = 1 (count 0), but no transfer is recorded while `rst_n` is low.
  - Reset mid-operation discards all queued loads.

## Timing

- ALU latency: `alu_valid` at edge N → `reg_write_en` high during cycle N+1; the register file commits at edge N+1.
- Load latency:
  - Empty queue, no ALU: accept at edge N → write cycle N+1.
  - Otherwise: +1 cycle per queued entry ahead, plus +1 per cycle with `alu_valid` asserted.
- Throughput: one write per cycle. A back-to-back ALU stream starves the queue indefinitely, and `ld_ready` falls once it is full.
- `busy` is registered-state derived (count != 0).

## Configuration

- Macro: `REGFILE_WB_BYPASS_EN`.
- Defined — adds the following ports:
  - `byp_index_a` in 5, `byp_index_b` in 5.
  - `byp_hit_a` out 1, `byp_hit_b` out 1.
  - `byp_data_a` out 32, `byp_data_b` out 32.
- Bypass behaviour:
  - `byp_hit_x` = `reg_write_en && write_index == byp_index_x && byp_index_x != 0`, combinational.
  - `byp_data_x` = `reg_write`, else 0.
  - This lets decode read a value being committed in the same cycle.
- Undefined: these ports are absent; no other behaviour changes.

## Test plan

- Reset, then `alu_valid`=1, rd=5, data=0x1234 at edge 1 → cycle 2: `reg_write_en`=1, `write_index`=5, `reg_write`=0x00001234; `alu_rd`=0 → `reg_write_en`=0.
- Load extension, empty queue, LB with `ld_addr_lo`=3 and rdata 0x80FF_0000 → 0xFFFFFF80; LHU with addr_lo=2 → 0x000080FF; LH addr_lo=0 with rdata 0x0000_8001 → 0xFFFF8001; each one cycle after accept.
- DEPTH=2: hold `alu_valid` high, offer 3 loads (rd 1,2,3) → `ld_ready` drops after two accepts, `busy`=1; drop `alu_valid` → rd 1 then rd 2 written on consecutive cycles, then load 3 accepted, written next cycle.
- Load with `ld_rd`=0 while queue empty and ALU idle → accepted, `reg_write_en` stays 0, `busy` stays 0.
- Assert `rst_n` low with 2 queued loads mid-stream → outputs 0 immediately (async), `busy`=0; after release no stale writes appear.
- With `REGFILE_WB_BYPASS_EN`: ALU write rd=7 data=0xDEAD in output stage, `byp_index_a`=7, `byp_index_b`=0 → `byp_hit_a`=1, `byp_data_a`=0xDEAD, `byp_hit_b`=0.
